// File: rtl/present_pkg.sv
// Shared PRESENT-80 definitions: S-box, permutation layer and engine FSM states.
// The round-key generator imports this package for its S-box as well.
package present_pkg;

  localparam int unsigned ROUNDS  = 31;
  localparam int unsigned BLOCK_W = 64;
  localparam int unsigned KEY_W   = 80;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } fsm_e;

  function automatic logic [BLOCK_W-1:0] s_layer(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int unsigned n = 0; n < BLOCK_W / 4; n++) begin
      y[4*n +: 4] = SBOX[x[4*n +: 4]];
    end
    return y;
  endfunction

  // Bit i lands at (16*i) mod 63; bit 63 is a fixed point.
  function automatic logic [BLOCK_W-1:0] p_layer(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int unsigned i = 0; i < BLOCK_W - 1; i++) begin
      y[(16 * i) % 63] = x[i];
    end
    y[BLOCK_W-1] = x[BLOCK_W-1];
    return y;
  endfunction

endpackage

// File: rtl/present_round.sv
// One PRESENT round, purely combinational: P(S(x ^ k)).
module present_round
  import present_pkg::*;
(
  input  logic [BLOCK_W-1:0] x,
  input  logic [BLOCK_W-1:0] k,
  output logic [BLOCK_W-1:0] y
);

  assign y = p_layer(s_layer(x ^ k));

endmodule

// File: rtl/present_round_engine.sv
// PRESENT-80 encryption datapath: 31 keyed rounds plus final whitening, with
// round keys streamed in order from the key generator over valid/ready.
module present_round_engine
  import present_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic [BLOCK_W-1:0] plaintext,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] round_key,
  input  logic               rk_valid,
  output logic               rk_ready,
  output logic [5:0]         round_idx,
  output logic [BLOCK_W-1:0] ciphertext,
  output logic               out_valid,
  input  logic               out_ready
);

  fsm_e               fsm_q, fsm_d;
  logic [BLOCK_W-1:0] state_q, state_d;
  logic [BLOCK_W-1:0] ct_q, ct_d;
  logic               ov_q, ov_d;
  logic [5:0]         idx_q, idx_d;
  logic [BLOCK_W-1:0] round_out;

  present_round u_round (
    .x (state_q),
    .k (round_key),
    .y (round_out)
  );

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    ct_d    = ct_q;
    ov_d    = ov_q;
    idx_d   = idx_q;
    unique case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = plaintext;
          idx_d   = 6'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        if (rk_valid) begin
          state_d = round_out;
          idx_d   = idx_q + 6'd1;
          if (idx_q == 6'(ROUNDS)) fsm_d = FINAL;
        end
      end
      FINAL: begin
        // Whitening key only: no S/P layer on the last key.
        if (rk_valid) begin
          ct_d  = state_q ^ round_key;
          idx_d = '0;
          ov_d  = 1'b1;
          fsm_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_d  = 1'b0;
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      ct_q    <= '0;
      ov_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      ct_q    <= ct_d;
      ov_q    <= ov_d;
      idx_q   <= idx_d;
    end
  end

  // Handshake readies come from the state register alone.
  assign in_ready   = (fsm_q == IDLE);
  assign rk_ready   = (fsm_q == ROUND) || (fsm_q == FINAL);
  assign round_idx  = idx_q;
  assign ciphertext = ct_q;
  assign out_valid  = ov_q;

endmodule

// File: tb/tb_present_round_engine.sv
// Bench for present_round_engine: table of known-answer and random vectors
// against a reference PRESENT-80 model, plus reset/backpressure sequences.
module tb_present_round_engine;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [63:0] plaintext;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] round_key;
  logic        rk_valid;
  logic        rk_ready;
  logic [5:0]  round_idx;
  logic [63:0] ciphertext;
  logic        out_valid;
  logic        out_ready;

  present_round_engine dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .plaintext  (plaintext),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .round_key  (round_key),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .round_idx  (round_idx),
    .ciphertext (ciphertext),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clock = ~clock;

  int unsigned edge_n = 0;
  always @(posedge clock) edge_n <= edge_n + 1;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [3:0]  sbox_tb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [63:0] rks [1:32];

  typedef struct {
    logic [79:0] key;
    logic [63:0] pt;
    logic [63:0] exp_ct;
    int unsigned stall_pct;
    int unsigned hold;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference key schedule: K_r is the top 64 bits of the 80-bit register.
  function automatic void build_keys(input logic [79:0] key);
    logic [79:0] kr;
    kr = key;
    for (int r = 1; r <= 32; r++) begin
      rks[r] = kr[79:16];
      kr = {kr[18:0], kr[79:19]};
      kr[79:76] = sbox_tb[kr[79:76]];
      kr[19:15] = kr[19:15] ^ 5'(r);
    end
  endfunction

  function automatic logic [63:0] ref_encrypt(input logic [63:0] pt);
    logic [63:0] s, t;
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ rks[r];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox_tb[s[4*n +: 4]];
      t = '0;
      for (int b = 0; b < 64; b++) t[(b == 63) ? 63 : (b * 16) % 63] = s[b];
      s = t;
    end
    return s ^ rks[32];
  endfunction

  task automatic pulse_reset();
    reset_n = 1'b0;
    rk_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  // Called #1 after a posedge with the engine in IDLE.
  task automatic run_block(input string tag, input logic [79:0] key, input logic [63:0] pt,
                           input int unsigned stall_pct, input int unsigned hold,
                           output logic [63:0] ct, output int unsigned start,
                           output int unsigned stalls);
    int unsigned n, cyc, lat;
    logic        v, idx_bad, hold_bad;
    logic [63:0] saved;
    build_keys(key);
    plaintext = pt;
    in_valid  = 1'b1;
    start     = edge_n;
    @(posedge clock); #1;
    in_valid = 1'b0;
    n = 0; cyc = 0; stalls = 0; idx_bad = 1'b0;
    while (!out_valid && cyc < 300) begin
      v = ($urandom_range(99) >= stall_pct) && (n < 32);
      rk_valid  = v;
      round_key = v ? rks[n+1] : {$urandom, $urandom};
      if (!rk_ready || round_idx != 6'(n + 1)) idx_bad = 1'b1;
      if (v && rk_ready) n++;
      else if (rk_ready) stalls++;
      @(posedge clock); #1;
      cyc++;
    end
    rk_valid = 1'b0;
    chk({tag, " out_valid"}, {63'd0, out_valid}, 64'd1);
    if (!out_valid) begin
      ct = ciphertext;
      pulse_reset();
      return;
    end
    lat = edge_n - start;
    chk({tag, " latency"}, 64'(lat), 64'(33 + stalls));
    chk({tag, " round_idx track"}, {63'd0, idx_bad}, 64'd0);
    ct = ciphertext;
    if (hold > 0) begin
      saved = ciphertext;
      hold_bad = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      plaintext = {$urandom, $urandom};
      repeat (hold) begin
        @(posedge clock); #1;
        if (!out_valid || ciphertext !== saved || in_ready) hold_bad = 1'b1;
      end
      in_valid = 1'b0;
      chk({tag, " backpressure hold"}, {63'd0, hold_bad}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk({tag, " back to idle"}, {56'd0, out_valid, in_ready, round_idx}, {56'd0, 1'b0, 1'b1, 6'd0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ct;
    int unsigned start, stalls, prev_start, prev_stalls;
    int unsigned n;

    reset_n = 1'b0; in_valid = 1'b0; plaintext = '0;
    rk_valid = 1'b0; round_key = '0; out_ready = 1'b0;
    #12;
    chk("reset in_ready",   {63'd0, in_ready},  64'd1);
    chk("reset rk_ready",   {63'd0, rk_ready},  64'd0);
    chk("reset out_valid",  {63'd0, out_valid}, 64'd0);
    chk("reset round_idx",  {58'd0, round_idx}, 64'd0);
    chk("reset ciphertext", ciphertext,         64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    rk_valid = 1'b1; round_key = {$urandom, $urandom};
    repeat (3) begin @(posedge clock); #1; end
    rk_valid = 1'b0;
    chk("idle ignores rk_valid", {57'd0, in_ready, round_idx}, {57'd0, 1'b1, 6'd0});

    vecs[0] = '{80'h0,                    64'h0,                  64'h5579C1387B228445, 0,  0};
    vecs[1] = '{80'hFFFFFFFFFFFFFFFFFFFF, 64'h0,                  64'hE72C46C0F5945049, 0,  0};
    vecs[2] = '{80'h0,                    64'hFFFFFFFFFFFFFFFF,   64'hA112FFC72F68417B, 0,  0};
    vecs[3] = '{80'hFFFFFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,   64'h3333DCD3213210D2, 0,  0};
    vecs[4] = '{80'h0,                    64'h0,                  64'h5579C1387B228445, 50, 0};
    vecs[5] = '{80'h0,                    64'h0,                  64'h5579C1387B228445, 0,  10};
    for (int i = 6; i < 10; i++) begin
      vecs[i].key       = {16'($urandom), $urandom, $urandom};
      vecs[i].pt        = {$urandom, $urandom};
      build_keys(vecs[i].key);
      vecs[i].exp_ct    = ref_encrypt(vecs[i].pt);
      vecs[i].stall_pct = 30;
      vecs[i].hold      = (i == 8) ? 3 : 0;
    end

    prev_start = 0; prev_stalls = 0;
    for (int i = 0; i < 10; i++) begin
      run_block($sformatf("vec%0d", i), vecs[i].key, vecs[i].pt, vecs[i].stall_pct,
                vecs[i].hold, ct, start, stalls);
      chk($sformatf("vec%0d ciphertext", i), ct, vecs[i].exp_ct);
      if (i > 0 && vecs[i-1].hold == 0)
        chk($sformatf("vec%0d back-to-back start", i), 64'(start - prev_start), 64'(34 + prev_stalls));
      prev_start = start; prev_stalls = stalls;
    end

    // Reset while round_idx == 15, then a fresh block.
    build_keys(80'h0);
    plaintext = 64'h0; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    n = 0;
    while (n < 14) begin
      rk_valid = 1'b1; round_key = rks[n+1];
      @(posedge clock); #1;
      n++;
    end
    chk("midop round_idx", {58'd0, round_idx}, 64'd15);
    reset_n = 1'b0;
    #1;
    chk("midop reset in_ready",   {63'd0, in_ready},  64'd1);
    chk("midop reset rk_ready",   {63'd0, rk_ready},  64'd0);
    chk("midop reset out_valid",  {63'd0, out_valid}, 64'd0);
    chk("midop reset round_idx",  {58'd0, round_idx}, 64'd0);
    chk("midop reset ciphertext", ciphertext,         64'd0);
    rk_valid = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("post reset no output", {63'd0, out_valid}, 64'd0);
    run_block("after reset", 80'hFFFFFFFFFFFFFFFFFFFF, 64'h0, 0, 0, ct, start, stalls);
    chk("after reset ciphertext", ct, 64'hE72C46C0F5945049);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
